// File: rtl/red_pitaya_sort_pulse.sv
// Sort actuator driver: rising edge of sort_trig_i -> delayed, gated bipolar square burst on the DAC.
// Optional macro SORT_PULSE_SW_TRIG_EN adds a write-only software trigger register at 0x2C.
`timescale 1ns/1ps
module red_pitaya_sort_pulse #(
  parameter int DWD = 14,
  parameter int CNT = 32
) (
  input  logic           adc_clk_i,
  input  logic           adc_rst_i,
  input  logic           sort_trig_i,
  output logic [DWD-1:0] dac_o,
  output logic           busy_o,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic [3:0]     sys_sel,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);

  localparam int AW = DWD - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_BURST   = 3'd2,
    ST_HOLDOFF = 3'd3
  } state_t;

  // Bus-visible configuration and counters
  logic           r_en, r_inv;
  logic [CNT-1:0] r_delay, r_hp, r_holdoff;
  logic [15:0]    r_cycles;
  logic [AW-1:0]  r_amp;
  logic [CNT-1:0] r_acc, r_drop;
  logic           r_ack;
  logic [31:0]    r_rdata;

  // Per-trigger shadow copies, so bus writes only affect the next trigger
  logic [CNT-1:0] r_s_delay, r_s_hp;
  logic [15:0]    r_s_cycles;
  logic [AW-1:0]  r_s_amp;
  logic           r_s_inv;

  state_t         r_state, w_state_nxt;
  logic [CNT-1:0] r_cnt, w_cnt_nxt, r_hcnt, w_hcnt_nxt;
  logic [16:0]    r_halfs, w_halfs_nxt;
  logic [DWD-1:0] r_dac, w_dac_nxt;
  logic           r_trig_q;

  logic [19:0]    w_addr;
  logic           w_clear, w_sw_edge, w_edge, w_accept, w_drop, w_busy;
  logic [DWD-1:0] w_pos, w_neg, w_first;
  logic [16:0]    w_last_half;
  logic [31:0]    w_rdata;
  logic           w_unused;

  assign w_addr  = sys_addr[19:0];
  assign w_clear = sys_wen && (w_addr == 20'h28) && sys_wdata[0];
`ifdef SORT_PULSE_SW_TRIG_EN
  assign w_sw_edge = sys_wen && (w_addr == 20'h2C) && sys_wdata[0];
`else
  assign w_sw_edge = 1'b0;
`endif
  assign w_edge      = (sort_trig_i & ~r_trig_q) | w_sw_edge;
  assign w_drop      = w_edge & ~w_accept;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_pos       = {1'b0, r_s_amp};
  assign w_neg       = -w_pos;
  assign w_first     = r_s_inv ? w_neg : w_pos;
  assign w_last_half = {r_s_cycles, 1'b0} - 17'd1;
  assign w_unused    = ^{sys_sel, sys_addr[31:20]};

  assign dac_o     = r_dac;
  assign busy_o    = w_busy;
  assign sys_rdata = r_rdata;
  assign sys_ack   = r_ack;
  assign sys_err   = 1'b0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hcnt_nxt  = r_hcnt;
    w_halfs_nxt = r_halfs;
    w_dac_nxt   = r_dac;
    w_accept    = 1'b0;
    if (!r_en) begin
      w_state_nxt = ST_IDLE;
      w_dac_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_edge) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_DELAY;
          w_cnt_nxt   = '0;
          w_dac_nxt   = '0;
        end
        ST_DELAY: if (r_cnt >= r_s_delay) begin
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = CNT'(1);
          w_halfs_nxt = '0;
          if (r_s_cycles == 16'd0) begin
            w_state_nxt = ST_HOLDOFF;
            w_dac_nxt   = '0;
          end else begin
            w_state_nxt = ST_BURST;
            w_dac_nxt   = w_first;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT'(1);
        end
        // r_hcnt counts clocks the current level has already been shown
        ST_BURST: if (r_hcnt >= r_s_hp) begin
          if (r_halfs == w_last_half) begin
            w_state_nxt = ST_HOLDOFF;
            w_dac_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_halfs_nxt = r_halfs + 17'd1;
            w_hcnt_nxt  = CNT'(1);
            w_dac_nxt   = -r_dac;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + CNT'(1);
        end
        ST_HOLDOFF: if (r_cnt >= r_holdoff) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT'(1);
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_dac_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_halfs  <= '0;
      r_dac    <= '0;
      r_trig_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_halfs  <= w_halfs_nxt;
      r_dac    <= w_dac_nxt;
      r_trig_q <= sort_trig_i;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      20'h00:  w_rdata = {30'd0, r_inv, r_en};
      20'h04:  w_rdata = 32'(r_delay);
      20'h08:  w_rdata = 32'(r_hp);
      20'h0C:  w_rdata = {16'd0, r_cycles};
      20'h10:  w_rdata = 32'(r_amp);
      20'h14:  w_rdata = 32'(r_holdoff);
      20'h18:  w_rdata = {28'd0, r_state, w_busy};
      20'h20:  w_rdata = 32'(r_acc);
      20'h24:  w_rdata = 32'(r_drop);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_en <= 1'b0;  r_inv <= 1'b0;
      r_delay <= '0; r_hp <= CNT'(63); r_cycles <= 16'd100;
      r_amp <= '0;   r_holdoff <= '0;
      r_acc <= '0;   r_drop <= '0;
      r_ack <= 1'b0; r_rdata <= '0;
      r_s_delay <= '0; r_s_hp <= CNT'(1); r_s_cycles <= '0;
      r_s_amp <= '0;   r_s_inv <= 1'b0;
    end else begin
      r_ack <= sys_wen | sys_ren;
      if (sys_ren) r_rdata <= w_rdata;
      if (sys_wen) begin
        case (w_addr)
          20'h00: begin r_en <= sys_wdata[0]; r_inv <= sys_wdata[1]; end
          20'h04: r_delay   <= sys_wdata[CNT-1:0];
          20'h08: r_hp      <= sys_wdata[CNT-1:0];
          20'h0C: r_cycles  <= sys_wdata[15:0];
          20'h10: r_amp     <= sys_wdata[AW-1:0];
          20'h14: r_holdoff <= sys_wdata[CNT-1:0];
          default: ;
        endcase
      end
      if (w_accept) begin
        r_s_delay  <= r_delay;
        r_s_hp     <= (r_hp == '0) ? CNT'(1) : r_hp;
        r_s_cycles <= r_cycles;
        r_s_amp    <= r_amp;
        r_s_inv    <= r_inv;
      end
      if (w_clear) begin
        r_acc  <= '0;
        r_drop <= '0;
      end else begin
        if (w_accept) r_acc  <= r_acc + CNT'(1);
        if (w_drop)   r_drop <= r_drop + CNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_sort_pulse.sv
// Directed bench for red_pitaya_sort_pulse: burst timing, drop/accept counting, bus map, abort and reset.
`timescale 1ns/1ps
module tb_red_pitaya_sort_pulse;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [13:0] dac;
  logic        busy;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0]  sel = 4'hF;
  logic        wen = 1'b0, ren = 1'b0, err, ack;

  int n_checks = 0;
  int n_fail   = 0;

  red_pitaya_sort_pulse #(.DWD(14), .CNT(32)) dut (
    .adc_clk_i(clk), .adc_rst_i(rst), .sort_trig_i(trig),
    .dac_o(dac), .busy_o(busy),
    .sys_addr(addr), .sys_wdata(wdata), .sys_sel(sel),
    .sys_wen(wen), .sys_ren(ren), .sys_rdata(rdata),
    .sys_err(err), .sys_ack(ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dac(input string tag, input int v);
    logic [13:0] e;
    e = 14'(v);
    chk(tag, {18'd0, dac}, {18'd0, e});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
    tick();
  endtask

  task automatic bus_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    chk(tag, rdata, exp);
    tick();
  endtask

  task automatic trig_pulse();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  // Called right after the edge-sampling clock; assumes holdoff = 0.
  task automatic expect_burst(input string tag, input int dly, input int first, input int hp, input int cyc);
    int lvl;
    for (int i = 0; i < dly; i++) begin
      tick();
      chk_dac({tag, "_delay"}, 0);
    end
    lvl = first;
    for (int p = 0; p < 2 * cyc; p++) begin
      for (int h = 0; h < hp; h++) begin
        tick();
        chk_dac({tag, "_level"}, lvl);
      end
      lvl = -lvl;
    end
    tick();
    chk_dac({tag, "_end"}, 0);
    chk({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
    tick();
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic base_config();
    bus_write(32'h00, 32'd1);
    bus_write(32'h04, 32'd10);
    bus_write(32'h08, 32'd4);
    bus_write(32'h0C, 32'd3);
    bus_write(32'h10, 32'd1000);
    bus_write(32'h14, 32'd0);
  endtask

  initial begin
    logic nonzero;

    // Reset state and register reset values
    repeat (3) tick();
    chk("rst_dac", {18'd0, dac}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();
    bus_read_chk("rst_ctrl", 32'h00, 32'd0);
    bus_read_chk("rst_hp", 32'h08, 32'd63);
    bus_read_chk("rst_cycles", 32'h0C, 32'd100);
    bus_read_chk("rst_status", 32'h18, 32'd0);
    bus_read_chk("unmapped_30", 32'h30, 32'd0);
    bus_read_chk("clear_reads0", 32'h28, 32'd0);
    bus_read_chk("addr_2c_reads0", 32'h2C, 32'd0);
    addr = 32'h04; wdata = 32'd7; wen = 1'b1;
    tick();
    wen = 1'b0;
    chk("wr_ack", {31'd0, ack}, 32'd1);
    tick();
    chk("ack_drop", {31'd0, ack}, 32'd0);

    // Basic burst with the trigger level held high across the whole burst
    base_config();
    trig = 1'b1;
    tick();
    chk("s1_busy_rise", {31'd0, busy}, 32'd1);
    bus_read_chk("s1_status", 32'h18, 32'h3);
    expect_burst("s1", 8, 1000, 4, 3);
    trig = 1'b0;
    bus_read_chk("s1_accepted", 32'h20, 32'd1);
    bus_read_chk("s1_dropped", 32'h24, 32'd0);

    // Inverted start, then full-scale amplitude
    bus_write(32'h00, 32'd3);
    trig_pulse();
    expect_burst("inv", 10, -1000, 4, 3);
    bus_write(32'h00, 32'd1);
    bus_write(32'h10, 32'd8191);
    bus_write(32'h0C, 32'd1);
    trig_pulse();
    expect_burst("amp_max", 10, 8191, 4, 1);
    bus_write(32'h10, 32'd1000);
    bus_write(32'h0C, 32'd3);

    // Edges during BURST and HOLDOFF are dropped
    bus_write(32'h28, 32'd1);
    bus_write(32'h14, 32'd50);
    trig_pulse();
    repeat (12) tick();
    trig_pulse();
    chk_dac("drop_burst_kept", 1000);
    repeat (26) tick();
    trig_pulse();
    chk_dac("drop_holdoff_dac", 0);
    chk("drop_holdoff_busy", {31'd0, busy}, 32'd1);
    repeat (50) tick();
    chk("holdoff_done", {31'd0, busy}, 32'd0);
    bus_read_chk("drop_dropped", 32'h24, 32'd2);
    bus_read_chk("drop_accepted", 32'h20, 32'd1);
    bus_write(32'h14, 32'd0);
    trig_pulse();
    expect_burst("after_idle", 10, 1000, 4, 3);
    bus_read_chk("after_idle_accepted", 32'h20, 32'd2);

    // Disabled trigger is dropped; disabling mid-burst aborts
    bus_write(32'h28, 32'd1);
    bus_write(32'h00, 32'd0);
    trig_pulse();
    nonzero = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (dac != '0 || busy) nonzero = 1'b1;
    end
    chk("dis_quiet", {31'd0, nonzero}, 32'd0);
    bus_read_chk("dis_dropped", 32'h24, 32'd1);
    bus_read_chk("dis_accepted", 32'h20, 32'd0);
    bus_write(32'h00, 32'd1);
    trig_pulse();
    repeat (12) tick();
    chk_dac("abort_pre", 1000);
    bus_write(32'h00, 32'd0);
    chk_dac("abort_dac", 0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    bus_read_chk("abort_status", 32'h18, 32'd0);
    bus_read_chk("abort_cnt_kept", 32'h20, 32'd1);

    // half_period written mid-burst only affects the next trigger
    bus_write(32'h00, 32'd1);
    trig_pulse();
    repeat (11) tick();
    bus_write(32'h08, 32'd8);
    chk_dac("hp_mid_a", 1000);
    tick();
    chk_dac("hp_mid_b", 1000);
    tick();
    chk_dac("hp_kept_4", -1000);
    repeat (30) tick();
    trig_pulse();
    expect_burst("hp8", 10, 1000, 8, 3);
    bus_write(32'h08, 32'd4);

    // cycles = 0: accepted but silent
    bus_write(32'h28, 32'd1);
    bus_write(32'h0C, 32'd0);
    trig_pulse();
    nonzero = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dac != '0) nonzero = 1'b1;
    end
    chk("cyc0_silent", {31'd0, nonzero}, 32'd0);
    chk("cyc0_idle", {31'd0, busy}, 32'd0);
    bus_read_chk("cyc0_accepted", 32'h20, 32'd1);
    bus_write(32'h0C, 32'd3);

    // Clear write coinciding with an accepted edge: clear wins
    trig = 1'b1; addr = 32'h28; wdata = 32'd1; wen = 1'b1;
    tick();
    trig = 1'b0; wen = 1'b0;
    chk("clr_race_busy", {31'd0, busy}, 32'd1);
    bus_read_chk("clr_race_accepted", 32'h20, 32'd0);
    repeat (40) tick();

    // Reset in the middle of a burst
    trig_pulse();
    repeat (12) tick();
    chk_dac("midrst_pre", 1000);
    rst = 1'b1;
    tick();
    chk_dac("midrst_dac", 0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    bus_read_chk("midrst_ctrl", 32'h00, 32'd0);
    bus_read_chk("midrst_hp", 32'h08, 32'd63);

`ifdef SORT_PULSE_SW_TRIG_EN
    base_config();
    addr = 32'h2C; wdata = 32'd1; wen = 1'b1;
    tick();
    wen = 1'b0;
    expect_burst("sw_trig", 10, 1000, 4, 3);
    bus_read_chk("sw_trig_accepted", 32'h20, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
